// File: rtl/vid2is_format_change_sequencer_pkg.sv
// Shared definitions for the Vid2IS format-change sequencer.
//   state_t     : sequencer states
//   SAMPLE_W    : width of committed width/height values
//   LINE_W      : width of a per-field line count
//   sat_inc8    : saturating 8-bit increment used by the change counter
package vid2is_format_change_sequencer_pkg;

  localparam int unsigned SAMPLE_W = 14;
  localparam int unsigned LINE_W   = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COMMIT,
    ST_REQ,
    ST_LOCKED
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vid2is_format_change_sequencer_if.sv
// Control-packet handshake and committed-format bus between the sequencer
// (master) and the downstream control-packet writer (slave).
//   ctrl_req       : request for a control packet (master -> slave)
//   ctrl_ack       : writer accepted the request (slave -> master)
//   fmt_width      : committed active width
//   fmt_height     : committed frame height
//   fmt_interlaced : committed interlace flag
//   format_valid   : committed format is current
interface vid2is_format_change_sequencer_if;
  import vid2is_format_change_sequencer_pkg::*;

  logic                ctrl_req;
  logic                ctrl_ack;
  logic [SAMPLE_W-1:0] fmt_width;
  logic [SAMPLE_W-1:0] fmt_height;
  logic                fmt_interlaced;
  logic                format_valid;

  modport master (
    output ctrl_req, fmt_width, fmt_height, fmt_interlaced, format_valid,
    input  ctrl_ack
  );

  modport slave (
    input  ctrl_req, fmt_width, fmt_height, fmt_interlaced, format_valid,
    output ctrl_ack
  );

endinterface

// File: rtl/vid2is_format_change_sequencer_toggle_edge.sv
// Toggle-to-pulse converter for the detector's toggle-coded outputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : toggle-coded input
//   toggled    : high while d differs from its registered copy
module vid2is_toggle_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic toggled
);

  logic q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign toggled = d ^ q;

endmodule

// File: rtl/vid2is_format_change_sequencer.sv
// Debounces resolution-detector format changes over STABLE_LINES lines,
// commits a shadow copy of the format and handshakes a control-packet
// request to the packet writer.
//   clk, rst_n           : clock, asynchronous active-low reset
//   enable, vid_locked   : run qualifiers; either low drives toward IDLE
//   start_new_line       : one-cycle line strobe
//   update               : detector toggle, any field changed
//   resolution_change    : detector toggle, resolution changed
//   stable               : detector line-consistency flag
//   resolution_valid     : detector all-fields-valid flag
//   interlaced           : detector interlace flag
//   active_sample_count  : {count[13:0], valid}
//   active_line_count_f0 : {count[12:0], valid}
//   active_line_count_f1 : {count[12:0], valid}
//   ctrl                 : request/ack handshake and committed format
//   change_count         : saturating count of format losses
//   default_width        : constant H_ACTIVE_PIXELS fallback width
module vid2is_format_change_sequencer
  import vid2is_format_change_sequencer_pkg::*;
#(
  parameter int unsigned STABLE_LINES    = 4,
  parameter int unsigned H_ACTIVE_PIXELS = 1920
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                vid_locked,
  input  logic                start_new_line,
  input  logic                update,
  input  logic                resolution_change,
  input  logic                stable,
  input  logic                resolution_valid,
  input  logic                interlaced,
  input  logic [SAMPLE_W:0]   active_sample_count,
  input  logic [LINE_W:0]     active_line_count_f0,
  input  logic [LINE_W:0]     active_line_count_f1,
  vid2is_format_change_sequencer_if.master ctrl,
  output logic [7:0]          change_count,
  output logic [SAMPLE_W-1:0] default_width
);

  localparam logic [7:0] LAST_LINE = 8'(STABLE_LINES - 1);

  state_t              state;
  logic [7:0]          line_cnt;
  logic                pending;
  logic                ctrl_req_q;
  logic [SAMPLE_W-1:0] fmt_width_q;
  logic [SAMPLE_W-1:0] fmt_height_q;
  logic                fmt_interlaced_q;
  logic                format_valid_q;
  logic [7:0]          change_count_q;

  logic                upd_edge;
  logic                res_edge;
  logic                any_edge;
  logic                run;
  logic                fmt_bad;
  logic [SAMPLE_W-1:0] height_sum;

  // Valid bits of the count inputs are redundant with resolution_valid.
  logic unused_valid_bits;
  assign unused_valid_bits = active_sample_count[0] ^ active_line_count_f0[0]
                           ^ active_line_count_f1[0];

  vid2is_toggle_edge u_update_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (update),
    .toggled (upd_edge)
  );

  vid2is_toggle_edge u_res_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (resolution_change),
    .toggled (res_edge)
  );

  assign any_edge = upd_edge | res_edge;
  assign run      = enable & vid_locked;
  assign fmt_bad  = ~stable | ~resolution_valid;

  // Frame height: field 0 plus field 1 when interlaced, wrapping at 14 bits.
  always_comb begin
    height_sum = {1'b0, active_line_count_f0[LINE_W:1]};
    if (interlaced) begin
      height_sum = height_sum + {1'b0, active_line_count_f1[LINE_W:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      line_cnt         <= '0;
      pending          <= 1'b0;
      ctrl_req_q       <= 1'b0;
      fmt_width_q      <= '0;
      fmt_height_q     <= '0;
      fmt_interlaced_q <= 1'b0;
      format_valid_q   <= 1'b0;
      change_count_q   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (run) begin
            state    <= ST_SETTLE;
            line_cnt <= '0;
            pending  <= 1'b0;
          end
        end

        ST_SETTLE: begin
          if (!run) begin
            state <= ST_IDLE;
          end else if (any_edge || fmt_bad) begin
            // An edge coinciding with a line strobe disqualifies that line.
            line_cnt <= '0;
          end else if (start_new_line) begin
            if (line_cnt == LAST_LINE) state <= ST_COMMIT;
            else                       line_cnt <= line_cnt + 8'd1;
          end
        end

        ST_COMMIT: begin
          fmt_width_q      <= active_sample_count[SAMPLE_W:1];
          fmt_height_q     <= height_sum;
          fmt_interlaced_q <= interlaced;
          if (any_edge) pending <= 1'b1;
          if (run) begin
            state      <= ST_REQ;
            ctrl_req_q <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_REQ: begin
          // Changes during the handshake are remembered so LOCKED re-settles.
          if (any_edge) pending <= 1'b1;
          if (ctrl_req_q && ctrl.ctrl_ack) begin
            ctrl_req_q <= 1'b0;
            if (run) begin
              state          <= ST_LOCKED;
              format_valid_q <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        ST_LOCKED: begin
          if (!run) begin
            state          <= ST_IDLE;
            format_valid_q <= 1'b0;
            change_count_q <= sat_inc8(change_count_q);
          end else if (res_edge || pending || fmt_bad) begin
            state          <= ST_SETTLE;
            line_cnt       <= '0;
            pending        <= 1'b0;
            format_valid_q <= 1'b0;
            change_count_q <= sat_inc8(change_count_q);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ctrl.ctrl_req       = ctrl_req_q;
  assign ctrl.fmt_width      = fmt_width_q;
  assign ctrl.fmt_height     = fmt_height_q;
  assign ctrl.fmt_interlaced = fmt_interlaced_q;
  assign ctrl.format_valid   = format_valid_q;
  assign change_count        = change_count_q;
  assign default_width       = SAMPLE_W'(H_ACTIVE_PIXELS);

endmodule
